// File: rtl/data_mem_ctrl_pkg.sv
// Shared definitions for the data-memory controller: access sizes, FSM states
// and the byte-lane enable decode used by stores.
package data_mem_ctrl_pkg;

   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;

   localparam int MAX_LANES = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_BUSY = 2'b01,
      ST_DONE = 2'b10
   } state_e;

   // Half accesses use the even/odd lane pair holding the addressed lane.
   function automatic logic [MAX_LANES-1:0] lane_en(input logic [1:0]  size,
                                                    input int unsigned lane,
                                                    input int unsigned nlanes);
      logic [MAX_LANES-1:0] m;
      m = '0;
      case (size)
         SZ_B:    m = MAX_LANES'(1) << lane;
         SZ_H:    m = MAX_LANES'(3) << (lane & ~32'd1);
         SZ_W:    m = {MAX_LANES{1'b1}} >> (MAX_LANES - nlanes);
         default: m = '0;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/data_mem_ctrl_ram.sv
// Word-organised RAM with per-byte write enables, one synchronous write port
// and two asynchronous read ports (access path and debug path).
module mem_lane_ram #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 9
) (
   input  logic                clk,
   input  logic [DATA_W/8-1:0] wr_be,
   input  logic [ADDR_W-1:0]   wr_addr,
   input  logic [DATA_W-1:0]   wr_data,
   input  logic [ADDR_W-1:0]   rd_addr,
   output logic [DATA_W-1:0]   rd_data,
   input  logic [ADDR_W-1:0]   dbg_addr,
   output logic [DATA_W-1:0]   dbg_data
);
   localparam int NB    = DATA_W / 8;
   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      for (int i = 0; i < NB; i++) begin
         if (wr_be[i]) mem[wr_addr][i*8 +: 8] <= wr_data[i*8 +: 8];
      end
   end

   assign rd_data  = mem[rd_addr];
   assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory controller: req/ready handshake with programmable wait states,
// byte/half/word stores with lane enables, extended loads and misalign detection.
module data_mem_ctrl
   import data_mem_ctrl_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 9,
   parameter int WAIT_CYC = 1
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               req,
   input  logic                               we,
   input  logic [1:0]                         size,
   input  logic                               sign_ext,
   input  logic [ADDR_W+$clog2(DATA_W/8)-1:0] addr,
   input  logic [DATA_W-1:0]                  wdata,
   output logic                               ready,
   output logic [DATA_W-1:0]                  rdata,
   output logic                               misalign,
   input  logic [ADDR_W-1:0]                  dbg_addr,
   output logic [DATA_W-1:0]                  dbg_data
);
   localparam int NB   = DATA_W / 8;
   localparam int LB   = $clog2(NB);
   localparam int BA_W = ADDR_W + LB;

   function automatic logic is_misaligned(input logic [1:0] sz, input logic [LB-1:0] low);
      case (sz)
         SZ_B:    return 1'b0;
         SZ_H:    return low[0];
         SZ_W:    return (low != '0);
         default: return 1'b1;
      endcase
   endfunction

   function automatic logic [DATA_W-1:0] ext_byte(input logic [7:0] b, input logic sx);
      return {{(DATA_W-8){sx & b[7]}}, b};
   endfunction

   function automatic logic [DATA_W-1:0] ext_half(input logic [15:0] h, input logic sx);
      return {{(DATA_W-16){sx & h[15]}}, h};
   endfunction

   state_e            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              mis_q, mis_d;
   logic              we_q, we_d;
   logic [1:0]        size_q, size_d;
   logic              sext_q, sext_d;
   logic [BA_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              pend_q, pend_d;

   logic [LB-1:0]     lane, hlane;
   logic              commit;
   logic [DATA_W-1:0] rd_word, wr_rep, load_val;
   logic [NB-1:0]     wr_be;

   assign lane   = addr_q[LB-1:0];
   assign hlane  = lane & ~LB'(1);
   assign commit = (state_q == ST_BUSY) && (cnt_q == 4'd0);

   // Store data is replicated across lanes so the lane enables alone place it.
   always_comb begin
      case (size_q)
         SZ_B:    wr_rep = {NB{wdata_q[7:0]}};
         SZ_H:    wr_rep = {(NB/2){wdata_q[15:0]}};
         default: wr_rep = wdata_q;
      endcase
      wr_be = '0;
      if (commit && we_q && !pend_q && !rst) wr_be = NB'(lane_en(size_q, 32'(lane), NB));
      case (size_q)
         SZ_B:    load_val = ext_byte(rd_word[{lane, 3'b000} +: 8], sext_q);
         SZ_H:    load_val = ext_half(rd_word[{hlane, 3'b000} +: 16], sext_q);
         default: load_val = rd_word;
      endcase
   end

   // Misaligned requests skip the wait states but still spend one cycle in BUSY.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      mis_d   = mis_q;
      we_d    = we_q;
      size_d  = size_q;
      sext_d  = sext_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      pend_d  = pend_q;
      case (state_q)
         ST_BUSY: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               state_d = ST_DONE;
               mis_d   = pend_q;
               if (pend_q)     rdata_d = '0;
               else if (!we_q) rdata_d = load_val;
            end
         end
         default: begin
            if (req) begin
               state_d = ST_BUSY;
               we_d    = we;
               size_d  = size;
               sext_d  = sign_ext;
               addr_d  = addr;
               wdata_d = wdata;
               pend_d  = is_misaligned(size, addr[LB-1:0]);
               cnt_d   = pend_d ? 4'd0 : 4'(WAIT_CYC);
            end else begin
               state_d = ST_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
         rdata_q <= '0;
         mis_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         mis_q   <= mis_d;
      end
   end

   always_ff @(posedge clk) begin
      we_q    <= we_d;
      size_q  <= size_d;
      sext_q  <= sext_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      pend_q  <= pend_d;
   end

   mem_lane_ram #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk      (clk),
      .wr_be    (wr_be),
      .wr_addr  (addr_q[BA_W-1:LB]),
      .wr_data  (wr_rep),
      .rd_addr  (addr_q[BA_W-1:LB]),
      .rd_data  (rd_word),
      .dbg_addr (dbg_addr),
      .dbg_data (dbg_data)
   );

   assign ready    = (state_q == ST_DONE);
   assign rdata    = rdata_q;
   assign misalign = mis_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: one instance with one wait state and one
// with none, sharing the request fields and the debug address.
module tb_data_mem_ctrl;
   import data_mem_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        rst, req1, req0, we, sign_ext;
   logic [1:0]  size;
   logic [10:0] addr;
   logic [31:0] wdata;
   logic [8:0]  dbg_addr;
   logic        ready1, mis1, ready0, mis0;
   logic [31:0] rdata1, dbg1, rdata0, dbg0;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic        w;
      logic [1:0]  sz;
      logic        sx;
      logic [10:0] a;
      logic [31:0] wd;
      logic [31:0] erd;
      logic        emis;
      logic [7:0]  elat;
      logic        chk;
   } op_t;

   op_t sb_q[$];

   always #5 clk = ~clk;

   data_mem_ctrl #(.DATA_W(32), .ADDR_W(9), .WAIT_CYC(1)) dut1 (
      .clk(clk), .rst(rst), .req(req1), .we(we), .size(size), .sign_ext(sign_ext),
      .addr(addr), .wdata(wdata), .ready(ready1), .rdata(rdata1), .misalign(mis1),
      .dbg_addr(dbg_addr), .dbg_data(dbg1));

   data_mem_ctrl #(.DATA_W(32), .ADDR_W(9), .WAIT_CYC(0)) dut0 (
      .clk(clk), .rst(rst), .req(req0), .we(we), .size(size), .sign_ext(sign_ext),
      .addr(addr), .wdata(wdata), .ready(ready0), .rdata(rdata0), .misalign(mis0),
      .dbg_addr(dbg_addr), .dbg_data(dbg0));

   function automatic op_t mk(input logic w, input logic [1:0] sz, input logic sx,
                              input logic [10:0] a, input logic [31:0] wd, input logic [31:0] erd,
                              input logic emis, input int elat, input logic chk);
      op_t o;
      o.w = w; o.sz = sz; o.sx = sx; o.a = a; o.wd = wd;
      o.erd = erd; o.emis = emis; o.elat = 8'(elat); o.chk = chk;
      return o;
   endfunction

   // lat counts falling edges after the request is driven; -1 means no ready seen.
   task automatic do_access(input logic sel, input logic w, input logic [1:0] sz, input logic sx,
                            input logic [10:0] a, input logic [31:0] wd,
                            output logic [31:0] rd, output logic mis, output int lat);
      @(negedge clk);
      we = w; size = sz; sign_ext = sx; addr = a; wdata = wd;
      if (sel) req1 = 1'b1; else req0 = 1'b1;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         req1 = 1'b0;
         req0 = 1'b0;
      end while (!(sel ? ready1 : ready0) && lat < 40);
      if (!(sel ? ready1 : ready0)) lat = -1;
      rd  = sel ? rdata1 : rdata0;
      mis = sel ? mis1 : mis0;
   endtask

   task automatic test_reset();
      rst = 1'b1; req1 = 1'b0; req0 = 1'b0; we = 1'b0; size = SZ_W; sign_ext = 1'b0;
      addr = '0; wdata = '0; dbg_addr = '0;
      repeat (3) @(negedge clk);
      checks++; if (ready1 !== 1'b0) begin errors++; $display("FAIL reset_ready1 got %b want 0", ready1); end
      checks++; if (rdata1 !== 32'h0) begin errors++; $display("FAIL reset_rdata1 got %h want 0", rdata1); end
      checks++; if (mis1 !== 1'b0) begin errors++; $display("FAIL reset_mis1 got %b want 0", mis1); end
      checks++; if (ready0 !== 1'b0) begin errors++; $display("FAIL reset_ready0 got %b want 0", ready0); end
      checks++; if (rdata0 !== 32'h0) begin errors++; $display("FAIL reset_rdata0 got %h want 0", rdata0); end
      rst = 1'b0;
   endtask

   task automatic test_word();
      op_t ops[$]; op_t e; logic [31:0] rd; logic mis; int lat;
      ops.push_back(mk(1'b1, SZ_W, 1'b0, 11'h010, 32'hDEADBEEF, '0, 1'b0, 3, 1'b0));
      ops.push_back(mk(1'b0, SZ_W, 1'b0, 11'h010, '0, 32'hDEADBEEF, 1'b0, 3, 1'b1));
      foreach (ops[i]) begin
         sb_q.push_back(ops[i]);
         do_access(1'b1, ops[i].w, ops[i].sz, ops[i].sx, ops[i].a, ops[i].wd, rd, mis, lat);
         e = sb_q.pop_front();
         checks++; if (lat !== int'(e.elat)) begin errors++; $display("FAIL word_lat[%0d] got %0d want %0d", i, lat, e.elat); end
         checks++; if (mis !== e.emis) begin errors++; $display("FAIL word_mis[%0d] got %b want %b", i, mis, e.emis); end
         if (e.chk) begin
            checks++; if (rd !== e.erd) begin errors++; $display("FAIL word_rdata[%0d] got %h want %h", i, rd, e.erd); end
         end
      end
      dbg_addr = 9'd4;
      #1;
      checks++; if (dbg1 !== 32'hDEADBEEF) begin errors++; $display("FAIL word_dbg got %h want deadbeef", dbg1); end
   endtask

   task automatic test_byte_half();
      op_t ops[$]; op_t e; logic [31:0] rd; logic mis; int lat;
      ops.push_back(mk(1'b1, SZ_W, 1'b0, 11'h020, 32'h0, '0, 1'b0, 3, 1'b0));
      ops.push_back(mk(1'b1, SZ_B, 1'b0, 11'h021, 32'hAAAAAA80, '0, 1'b0, 3, 1'b0));
      ops.push_back(mk(1'b0, SZ_B, 1'b1, 11'h021, '0, 32'hFFFFFF80, 1'b0, 3, 1'b1));
      ops.push_back(mk(1'b0, SZ_B, 1'b0, 11'h021, '0, 32'h00000080, 1'b0, 3, 1'b1));
      ops.push_back(mk(1'b1, SZ_H, 1'b0, 11'h022, 32'h12348001, '0, 1'b0, 3, 1'b0));
      ops.push_back(mk(1'b0, SZ_H, 1'b1, 11'h022, '0, 32'hFFFF8001, 1'b0, 3, 1'b1));
      ops.push_back(mk(1'b0, SZ_H, 1'b0, 11'h022, '0, 32'h00008001, 1'b0, 3, 1'b1));
      ops.push_back(mk(1'b0, SZ_B, 1'b1, 11'h023, '0, 32'hFFFFFF80, 1'b0, 3, 1'b1));
      ops.push_back(mk(1'b0, SZ_W, 1'b0, 11'h020, '0, 32'h80018000, 1'b0, 3, 1'b1));
      foreach (ops[i]) begin
         sb_q.push_back(ops[i]);
         do_access(1'b1, ops[i].w, ops[i].sz, ops[i].sx, ops[i].a, ops[i].wd, rd, mis, lat);
         e = sb_q.pop_front();
         checks++; if (lat !== int'(e.elat)) begin errors++; $display("FAIL bh_lat[%0d] got %0d want %0d", i, lat, e.elat); end
         if (e.chk) begin
            checks++; if (rd !== e.erd) begin errors++; $display("FAIL bh_rdata[%0d] got %h want %h", i, rd, e.erd); end
         end
      end
   endtask

   task automatic test_misalign();
      op_t ops[$]; op_t e; logic [31:0] rd; logic mis; int lat;
      ops.push_back(mk(1'b1, SZ_W, 1'b0, 11'h000, 32'hCAFEF00D, '0, 1'b0, 3, 1'b0));
      ops.push_back(mk(1'b0, SZ_W, 1'b0, 11'h000, '0, 32'hCAFEF00D, 1'b0, 3, 1'b1));
      ops.push_back(mk(1'b0, SZ_W, 1'b0, 11'h002, '0, 32'h0, 1'b1, 2, 1'b1));
      ops.push_back(mk(1'b1, SZ_H, 1'b0, 11'h003, 32'h0000FFFF, 32'h0, 1'b1, 2, 1'b1));
      ops.push_back(mk(1'b0, SZ_H, 1'b1, 11'h001, '0, 32'h0, 1'b1, 2, 1'b1));
      ops.push_back(mk(1'b1, 2'b11, 1'b0, 11'h000, 32'h0, 32'h0, 1'b1, 2, 1'b1));
      ops.push_back(mk(1'b0, SZ_B, 1'b0, 11'h003, '0, 32'h000000CA, 1'b0, 3, 1'b1));
      ops.push_back(mk(1'b0, SZ_W, 1'b0, 11'h000, '0, 32'hCAFEF00D, 1'b0, 3, 1'b1));
      foreach (ops[i]) begin
         sb_q.push_back(ops[i]);
         do_access(1'b1, ops[i].w, ops[i].sz, ops[i].sx, ops[i].a, ops[i].wd, rd, mis, lat);
         e = sb_q.pop_front();
         checks++; if (lat !== int'(e.elat)) begin errors++; $display("FAIL mis_lat[%0d] got %0d want %0d", i, lat, e.elat); end
         checks++; if (mis !== e.emis) begin errors++; $display("FAIL mis_flag[%0d] got %b want %b", i, mis, e.emis); end
         if (e.chk) begin
            checks++; if (rd !== e.erd) begin errors++; $display("FAIL mis_rdata[%0d] got %h want %h", i, rd, e.erd); end
         end
      end
      dbg_addr = 9'd0;
      #1;
      checks++; if (dbg1 !== 32'hCAFEF00D) begin errors++; $display("FAIL mis_dbg got %h want cafef00d", dbg1); end
   endtask

   // Zero-wait instance, req held high: store/load pairs alternate every two cycles.
   task automatic test_back_to_back();
      logic [31:0] v[3]; op_t e; int k;
      v[0] = 32'h11223344; v[1] = 32'hA5A55A5A; v[2] = 32'h0F0F0F0F;
      @(negedge clk);
      we = 1'b1; size = SZ_W; sign_ext = 1'b0; addr = 11'h030; wdata = v[0]; req0 = 1'b1;
      for (int cyc = 1; cyc <= 13; cyc++) begin
         @(negedge clk);
         checks++;
         if (ready0 !== ((cyc % 2) == 0)) begin
            errors++; $display("FAIL b2b_ready[%0d] got %b want %b", cyc, ready0, ((cyc % 2) == 0));
         end
         if ((cyc % 2) == 0) begin
            k = cyc / 2 - 1;
            if ((k % 2) == 1 && sb_q.size() > 0) begin
               e = sb_q.pop_front();
               checks++;
               if (rdata0 !== e.erd) begin errors++; $display("FAIL b2b_rdata[%0d] got %h want %h", cyc, rdata0, e.erd); end
            end
         end else begin
            k = (cyc + 1) / 2;
            if (k < 6) begin
               we = ((k % 2) == 0);
               wdata = ((k % 2) == 0) ? v[k/2] : 32'h0;
               if ((k % 2) == 1) sb_q.push_back(mk(1'b0, SZ_W, 1'b0, 11'h030, '0, v[(k-1)/2], 1'b0, 2, 1'b1));
            end else begin
               req0 = 1'b0;
            end
         end
      end
   endtask

   task automatic test_busy_ignored();
      logic [31:0] rd; logic mis; int lat; int pulses; int first;
      do_access(1'b1, 1'b1, SZ_W, 1'b0, 11'h054, 32'h77777777, rd, mis, lat);
      pulses = 0; first = -1;
      @(negedge clk);
      we = 1'b1; size = SZ_W; addr = 11'h050; wdata = 32'h55AA55AA; req1 = 1'b1;
      for (int cyc = 1; cyc <= 8; cyc++) begin
         @(negedge clk);
         if (cyc == 1) begin addr = 11'h054; wdata = 32'h0BADF00D; end
         if (cyc == 2) req1 = 1'b0;
         if (ready1) begin pulses++; if (first < 0) first = cyc; end
      end
      checks++; if (pulses != 1) begin errors++; $display("FAIL busy_pulses got %0d want 1", pulses); end
      checks++; if (first != 3) begin errors++; $display("FAIL busy_latency got %0d want 3", first); end
      dbg_addr = 9'h14;
      #1;
      checks++; if (dbg1 !== 32'h55AA55AA) begin errors++; $display("FAIL busy_dbg14 got %h want 55aa55aa", dbg1); end
      dbg_addr = 9'h15;
      #1;
      checks++; if (dbg1 !== 32'h77777777) begin errors++; $display("FAIL busy_dbg15 got %h want 77777777", dbg1); end
   endtask

   // Reset lands on the edge that would commit the store.
   task automatic test_reset_mid_access();
      logic [31:0] rd; logic mis; int lat; int pulses;
      do_access(1'b1, 1'b1, SZ_W, 1'b0, 11'h040, 32'h11111111, rd, mis, lat);
      do_access(1'b1, 1'b0, SZ_W, 1'b0, 11'h040, 32'h0, rd, mis, lat);
      checks++; if (rd !== 32'h11111111) begin errors++; $display("FAIL rst_pre_rdata got %h want 11111111", rd); end
      pulses = 0;
      @(negedge clk);
      we = 1'b1; size = SZ_W; addr = 11'h040; wdata = 32'h12345678; req1 = 1'b1;
      for (int cyc = 1; cyc <= 6; cyc++) begin
         @(negedge clk);
         if (cyc == 1) req1 = 1'b0;
         if (cyc == 2) rst = 1'b1;
         if (cyc == 3) begin
            rst = 1'b0;
            checks++; if (rdata1 !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h want 0", rdata1); end
            checks++; if (mis1 !== 1'b0) begin errors++; $display("FAIL rst_mis got %b want 0", mis1); end
         end
         if (ready1) pulses++;
      end
      checks++; if (pulses != 0) begin errors++; $display("FAIL rst_pulses got %0d want 0", pulses); end
      dbg_addr = 9'h10;
      #1;
      checks++; if (dbg1 !== 32'h11111111) begin errors++; $display("FAIL rst_dbg got %h want 11111111", dbg1); end
   endtask

   initial begin
      test_reset();
      test_word();
      test_byte_half();
      test_misalign();
      test_back_to_back();
      test_busy_ignored();
      test_reset_mid_access();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
